// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment bank.
// Presents one shadowed nibble per prescaled slot with one-hot enable, blank and frame flags.
module seg7_scan_ctrl #(
  parameter int NDIG         = 8,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] DATA,
  input  logic              LOAD,
  input  logic              LZB,
  input  logic [NDIG-1:0]   BLINK,
  output logic [3:0]        HEX,
  output logic [NDIG-1:0]   DIGIT_SEL,
  output logic              BLANK,
  output logic              FRAME
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              frame_seen_q, frame_seen_d;
  logic [3:0]        hex_q, hex_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic              blank_q, blank_d;
  logic              frame_q, frame_d;

  logic              tick;
  logic              wrap;
  logic              zero_acc;
  logic [NDIG-1:0]   zero_from;
  logic [3:0]        nib [NDIG];

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
    assign nib[gi] = shadow_q[4*gi +: 4];
  end

  // zero_from[i] is set when shadow digits i..NDIG-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (shadow_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    tick          = (presc_q == PRE_LAST);
    wrap          = tick && (idx_q == IDX_LAST);
    presc_d       = tick ? '0 : presc_q + PW'(1);
    idx_d         = idx_q;
    shadow_d      = LOAD ? DATA : shadow_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_seen_d  = frame_seen_q;
    hex_d         = hex_q;
    sel_d         = sel_q;
    blank_d       = blank_q;
    frame_d       = wrap;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    // The first frame after reset starts the count; each later frame start closes one frame.
    if (wrap) begin
      frame_seen_d = 1'b1;
      if (frame_seen_q) begin
        if (blink_cnt_q == BLK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end

    // shadow_q is still the pre-LOAD value here, so a coincident LOAD shows next slot.
    if (tick) begin
      hex_d   = nib[idx_d];
      sel_d   = NDIG'(1) << idx_d;
      blank_d = (LZB && (idx_d != '0) && zero_from[idx_d]) ||
                (BLINK[idx_d] && blink_phase_d);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q       <= '0;
      idx_q         <= IDX_LAST;
      shadow_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_seen_q  <= 1'b0;
      hex_q         <= 4'd0;
      sel_q         <= '0;
      blank_q       <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_seen_q  <= frame_seen_d;
      hex_q         <= hex_d;
      sel_q         <= sel_d;
      blank_q       <= blank_d;
      frame_q       <= frame_d;
    end
  end

  assign HEX       = hex_q;
  assign DIGIT_SEL = sel_q;
  assign BLANK     = blank_q;
  assign FRAME     = frame_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode/cathode 7-segment digits.
- Holds NDIG hex nibbles in a shadow register and cycles through the digits at a prescaled rate.
- Each step presents one nibble on HEX to the downstream hex-to-segment decoder, with a one-hot digit enable and a blank flag.
- Supports leading-zero suppression and per-digit blinking.

Parameters:
- NDIG, 8, number of digits scanned (2..16).
- PRESCALE, 50000, CLK cycles per digit slot (>=2).
- BLINK_FRAMES, 64, complete scan frames per blink half-period (>=1).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  4*NDIG  digit nibbles; digit i = DATA[4i+3:4i]; digit 0 is least significant.
- LOAD  in  1  single-cycle strobe; captures DATA into the shadow register.
- LZB  in  1  1 = leading-zero blanking enabled.
- BLINK  in  NDIG  per-digit blink mask; bit i = 1 makes digit i blink.
- HEX  out  4  nibble for the current digit; feeds the decoder.
- DIGIT_SEL  out  NDIG  one-hot, active-high digit enable.
- BLANK  out  1  1 = segments for the current slot must be forced off downstream.
- FRAME  out  1  one-cycle pulse at the start of each scan frame (digit 0 selected).

Behaviour:
- Reset (RST=0, async):
  - prescaler=0; index=NDIG-1; shadow=0; blink counter=0; blink phase=0.
  - HEX=0, DIGIT_SEL=0 (all digits off), BLANK=1, FRAME=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is asserted on the cycle the count equals PRESCALE-1.
  - First tick occurs PRESCALE cycles after reset release.
- Index:
  - On tick, index increments; NDIG-1 wraps to 0.
  - Reset value NDIG-1 makes the first tick select digit 0.
- Outputs:
  - Registered. Updated on the same edge that advances index; values correspond to the new index.
  - Between ticks HEX, DIGIT_SEL and BLANK hold steady.
  - DIGIT_SEL has exactly one bit set after the first tick, never zero and never more than one bit set thereafter.
- FRAME:
  - Asserted for one cycle on the edge where index wraps to 0, including the first tick after reset.
- Shadow register:
  - When LOAD=1, shadow<=DATA on that edge. No other path updates it.
  - If LOAD and tick coincide, the output computation uses the OLD shadow. The new value is visible from the next tick.
- Leading-zero blanking:
  - Digit i (i>=1) is suppressed if LZB=1 and shadow digits i..NDIG-1 are all 0.
  - Digit 0 is never suppressed, so value 0 displays as a single "0".
- Blink:
  - Blink counter counts FRAME pulses 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
  - Digit i is suppressed when BLINK[i]=1 and phase=1.
- BLANK = leading-zero suppression OR blink suppression for the selected digit.
- HEX still carries the shadow nibble when BLANK=1; downstream gating of BLANK is mandatory.
- LZB and BLINK are sampled combinationally at each tick; changes mid-slot take effect at the next tick.
- Reset mid-operation returns to the reset state immediately, regardless of prescaler or index position.

Test Plan:
- NDIG=4, PRESCALE=4: release RST, no LOAD -> DIGIT_SEL=0000, BLANK=1 for cycles 0-3; at cycle 4 DIGIT_SEL=0001, HEX=0, BLANK=0 (LZB=0), FRAME=1 for one cycle.
- LOAD DATA=16'h1A3F, LZB=0 -> successive slots give HEX=F,3,A,1 with DIGIT_SEL=0001,0010,0100,1000, then wrap to 0001 with a FRAME pulse; each slot lasts exactly 4 cycles.
- LOAD DATA=16'h0050, LZB=1 -> digit0 HEX=0 BLANK=0; digit1 HEX=5 BLANK=0; digits 2,3 BLANK=1. LOAD DATA=16'h0000 -> only digit0 unblanked, showing 0.
- BLINK_FRAMES=2, BLINK=4'b0010, DATA=16'h1234 -> digit1 BLANK=0 for frames 0-1, BLANK=1 for frames 2-3, repeating; other digits never blanked.
- LOAD asserted on the same edge as a tick into digit2, with old=16'h1111 and new=16'h2222 -> digit2 slot shows HEX=1; the next slot (digit3) shows HEX=2.
- Assert RST low mid-slot (index=2, prescaler=1) -> outputs immediately DIGIT_SEL=0, BLANK=1, HEX=0, shadow cleared; after release, first tick again falls 4 cycles later on digit 0.
